energy_window_power_monitor: RTL and testbench
==============================================

Name: energy_window_power_monitor

Overview:
Reader-side companion to the tile energy accumulators. It samples a free-running 64-bit energy counter (pJ) over fixed windows of 2^LOG2_WINDOW cycles and converts each window delta back into average power in mW, using the same integer cycle-time convention as the accumulators: cycle_time_ps = 1000000 / freq_MHz. It posts each power sample on a valid/ready interface and drives a hysteretic throttle request against a programmable budget. It sits between the tile energy counters and the DVFS/power-management controller.

Parameters:
LOG2_WINDOW, 8, window length = 2^LOG2_WINDOW cycles; legal range 6..20 (window must exceed the divide latency).
DIV_W, 48, dividend width of the iterative divide; also the number of divide iterations.

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
enable  input  1  monitoring enable
total_energy_pj  input  64  running energy counter from the accumulator; wraps modulo 2^64
current_freq_mhz  input  16  current operating frequency
budget_mw  input  16  power budget; 0 disables throttling
hyst_mw  input  16  hysteresis band
sample_ready  input  1  consumer accepts the sample
sample_valid  output  1  avg_power_mw holds an unconsumed sample
avg_power_mw  output  16  average power of the last completed window
throttle_req  output  1  request to throttle
sample_overrun  output  1  sticky; set when an unconsumed sample was overwritten
window_count  output  32  number of completed windows; wraps

Behaviour:
- Reset: all outputs 0; internal snapshot 0; window counter 0; FSM in IDLE.
- FSM states:
  - IDLE: entered on reset, and from RUN when enable is low.
  - RUN: counting the window.
  - DIV: divide in progress.
  - POST: publish the result.
- In IDLE, snapshot <= total_energy_pj every cycle and win_cnt <= 0. When enable=1, go to RUN.
- In RUN, win_cnt increments each cycle. On the edge where win_cnt == 2^LOG2_WINDOW-1 (edge E0):
  - delta = total_energy_pj - snapshot, 64-bit modulo, so counter wrap is handled.
  - epc = delta >> LOG2_WINDOW.
  - dividend = min(epc*1000, 2^DIV_W-1).
  - divisor = (current_freq_mhz != 0) ? 1000000/current_freq_mhz : 0, 32 bits.
  - snapshot <= total_energy_pj; win_cnt <= 0; start the divider; state -> DIV.
- Window counting continues during DIV and POST.
- If enable falls while in RUN, go to IDLE and discard the partial window.
- If enable falls during DIV or POST, the divide completes and the result is posted, then the FSM goes to IDLE.
- DIV: restoring divide, one quotient bit per cycle, DIV_W cycles, then go to POST.
- POST (edge E0+DIV_W+1):
  - quotient saturates to 16 bits (0xFFFF if larger); divisor == 0 forces a result of 0.
  - avg_power_mw <= result; sample_valid <= 1; window_count += 1.
  - If sample_valid && !sample_ready on that same edge, set sample_overrun (sticky until reset).
  - Then return to RUN (or IDLE if enable is low).
- Fixed latency: sample_valid rises DIV_W+1 edges after E0, i.e. 49 with the defaults.
- Handshake:
  - sample_valid clears on any edge where sample_valid && sample_ready.
  - avg_power_mw is held stable while valid.
  - If a POST coincides with an acceptance, the new sample wins and no overrun is flagged.
- Throttle, updated only in POST using the new result:
  - budget_mw == 0: throttle_req <= 0.
  - else if result >= budget_mw: throttle_req <= 1.
  - else if result < sat0(budget_mw - hyst_mw): throttle_req <= 0.
  - otherwise hold.
- Mid-window frequency changes: the divisor uses the frequency sampled at E0 only. This is a documented approximation.
- Asynchronous reset during DIV aborts the divide; all outputs go to 0 immediately.

Decomposition:
- Package energy_pkg holds:
  - PS_PER_US = 1000000
  - MW_SCALE = 1000
  - FSM state enum {IDLE, RUN, DIV, POST}
  - saturation helpers
- One sub-module, energy_seq_divider: a restoring unsigned divider with start/busy/done.
  - DIV_W-bit dividend, 32-bit divisor, DIV_W-bit quotient.
  - Fixed DIV_W-cycle latency; divide-by-zero returns 0.

Test Plan:
1. LOG2_WINDOW=6, freq=1000, counter +500 pJ/cycle, sample_ready=1 -> avg_power_mw=500, valid exactly 49 cycles after window end, window_count=1.
2. freq=200 (cycle 5000 ps), counter +1500 pJ/cycle -> avg_power_mw=300. Switch to freq=0 -> next sample is 0.
3. snapshot=2^64-1000, counter +500/cycle across the wrap -> delta correct, avg_power_mw=500 at 1000 MHz.
4. budget=400, hyst=50; run powers 500, 380, 340 -> throttle_req 1, 1 (380 is inside the band), 0. budget=0 -> throttle_req stays 0.
5. sample_ready=0 for two windows -> sample_overrun=1, avg_power_mw holds the second sample. POST coinciding with acceptance -> no overrun.
6. Drop enable mid-RUN -> no sample posted. Drop enable mid-DIV -> the sample still posts, then IDLE. Assert reset mid-DIV -> all outputs 0 immediately, and the first post-reset window reports correctly.

Source files
------------

// File: rtl/energy_pkg.sv
// Shared constants, FSM state type and saturation helpers for the energy window power monitor.
package energy_pkg;

    localparam int unsigned PS_PER_US = 1000000;
    localparam int unsigned MW_SCALE  = 1000;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDiv,
        StPost
    } state_e;

    function automatic logic [15:0] sat_u16(input logic [63:0] value);
        return (value > 64'h0000_0000_0000_FFFF) ? 16'hFFFF : value[15:0];
    endfunction

    function automatic logic [15:0] sat0_sub16(input logic [15:0] a, input logic [15:0] b);
        return (a > b) ? (a - b) : 16'h0000;
    endfunction

endpackage

// File: rtl/energy_seq_divider.sv
// Restoring unsigned divider, one quotient bit per cycle; divide-by-zero yields 0.
module energy_seq_divider #(
    parameter int unsigned DIV_W = 48
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [DIV_W-1:0] dividend,
    input  logic [31:0]      divisor,
    output logic             busy,
    output logic             done,
    output logic [DIV_W-1:0] quotient
);

    localparam int unsigned CNT_W = $clog2(DIV_W + 1);
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      rem_q;
    logic [31:0]      dsr_q;
    logic [DIV_W-1:0] quo_q;
    logic             zero_q;

    logic [32:0] trial;
    logic [32:0] diff;
    logic        fits;
    logic [31:0] rem_d;

    always_comb begin
        trial = {rem_q, quo_q[DIV_W-1]};
        diff  = trial - {1'b0, dsr_q};
        fits  = (trial >= {1'b0, dsr_q});
        rem_d = fits ? diff[31:0] : trial[31:0];
    end

    // Quotient bits shift in behind the dividend bits being consumed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            rem_q  <= '0;
            dsr_q  <= '0;
            quo_q  <= '0;
            zero_q <= 1'b0;
        end else if (start) begin
            cnt_q  <= CNT_W'(DIV_W);
            rem_q  <= '0;
            dsr_q  <= divisor;
            quo_q  <= dividend;
            zero_q <= (divisor == 32'h0);
        end else if (busy) begin
            cnt_q <= cnt_q - CNT_ONE;
            rem_q <= rem_d;
            quo_q <= {quo_q[DIV_W-2:0], fits};
        end
    end

    assign busy     = (cnt_q != '0);
    // High during the final iteration; the quotient is complete from the next cycle on.
    assign done     = (cnt_q == CNT_ONE);
    assign quotient = zero_q ? '0 : quo_q;

endmodule

// File: rtl/energy_window_power_monitor.sv
// Converts per-window energy-counter deltas into average power (mW) and drives a hysteretic
// throttle request against a programmable budget.
module energy_window_power_monitor
    import energy_pkg::*;
#(
    parameter int unsigned LOG2_WINDOW = 8,
    parameter int unsigned DIV_W       = 48
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [63:0] total_energy_pj,
    input  logic [15:0] current_freq_mhz,
    input  logic [15:0] budget_mw,
    input  logic [15:0] hyst_mw,
    input  logic        sample_ready,
    output logic        sample_valid,
    output logic [15:0] avg_power_mw,
    output logic        throttle_req,
    output logic        sample_overrun,
    output logic [31:0] window_count
);

    localparam logic [LOG2_WINDOW-1:0] WIN_ONE = 1;
    localparam logic [73:0] DIV_MAX = (74'(1) << DIV_W) - 74'(1);

    state_e state_q, state_d;

    logic [LOG2_WINDOW-1:0] win_cnt_q;
    logic [63:0]            snapshot_q;
    logic                   valid_q;
    logic                   throttle_q;
    logic                   overrun_q;
    logic [15:0]            avg_q;
    logic [31:0]            wcount_q;

    logic [63:0]      epc;
    logic [73:0]      scaled;
    logic [DIV_W-1:0] dividend;
    logic [31:0]      divisor;
    logic             div_start;
    logic             div_busy;
    logic             div_done;
    logic [DIV_W-1:0] div_quot;
    logic             publish;
    logic [15:0]      result;
    logic             throttle_d;

    // Modulo-2^64 subtraction absorbs counter wrap within a window.
    always_comb begin
        epc      = (total_energy_pj - snapshot_q) >> LOG2_WINDOW;
        scaled   = 74'(epc) * 74'(MW_SCALE);
        dividend = (scaled > DIV_MAX) ? DIV_MAX[DIV_W-1:0] : scaled[DIV_W-1:0];
        divisor  = (current_freq_mhz != 16'h0)
                 ? (32'(PS_PER_US) / {16'h0, current_freq_mhz}) : 32'h0;
    end

    energy_seq_divider #(
        .DIV_W (DIV_W)
    ) u_div (
        .clk      (clk),
        .reset    (reset),
        .start    (div_start),
        .dividend (dividend),
        .divisor  (divisor),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_quot)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: if (enable) state_d = StRun;
            StRun: begin
                if (!enable) begin
                    state_d = StIdle;
                end else if (&win_cnt_q) begin
                    state_d = StDiv;
                end
            end
            StDiv:   if (div_done) state_d = StPost;
            StPost:  state_d = enable ? StRun : StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        div_start = (state_q == StRun) && enable && (&win_cnt_q);
        publish   = (state_q == StPost) && !div_busy;
    end

    always_comb begin
        result     = sat_u16(64'(div_quot));
        throttle_d = throttle_q;
        if (budget_mw == 16'h0) begin
            throttle_d = 1'b0;
        end else if (result >= budget_mw) begin
            throttle_d = 1'b1;
        end else if (result < sat0_sub16(budget_mw, hyst_mw)) begin
            throttle_d = 1'b0;
        end
    end

    // A post on the same edge as an acceptance keeps the new sample valid and is no overrun.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            win_cnt_q  <= '0;
            snapshot_q <= '0;
            valid_q    <= 1'b0;
            throttle_q <= 1'b0;
            overrun_q  <= 1'b0;
            avg_q      <= '0;
            wcount_q   <= '0;
        end else begin
            win_cnt_q <= (state_q == StIdle) ? '0 : (win_cnt_q + WIN_ONE);
            if ((state_q == StIdle) || div_start) begin
                snapshot_q <= total_energy_pj;
            end
            if (publish) begin
                avg_q      <= result;
                valid_q    <= 1'b1;
                wcount_q   <= wcount_q + 32'd1;
                throttle_q <= throttle_d;
                if (valid_q && !sample_ready) begin
                    overrun_q <= 1'b1;
                end
            end else if (valid_q && sample_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign sample_valid   = valid_q;
    assign avg_power_mw   = avg_q;
    assign throttle_req   = throttle_q;
    assign sample_overrun = overrun_q;
    assign window_count   = wcount_q;

endmodule

// File: tb/tb_energy_window_power_monitor.sv
// Scoreboard bench: stimulus pushes predicted samples, a negedge monitor pops and compares.
module tb_energy_window_power_monitor;

    localparam int unsigned L   = 6;
    localparam int unsigned WIN = 64;
    localparam int unsigned LAT = 49;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic [63:0] total = '0;
    logic [15:0] freq = '0;
    logic [15:0] budget = '0;
    logic [15:0] hyst = '0;
    logic        ready = 1'b1;
    logic        sample_valid;
    logic [15:0] avg_power_mw;
    logic        throttle_req;
    logic        sample_overrun;
    logic [31:0] window_count;

    energy_window_power_monitor #(
        .LOG2_WINDOW (L),
        .DIV_W       (48)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .enable           (enable),
        .total_energy_pj  (total),
        .current_freq_mhz (freq),
        .budget_mw        (budget),
        .hyst_mw          (hyst),
        .sample_ready     (ready),
        .sample_valid     (sample_valid),
        .avg_power_mw     (avg_power_mw),
        .throttle_req     (throttle_req),
        .sample_overrun   (sample_overrun),
        .window_count     (window_count)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        longint unsigned power;
        bit              thr;
        longint unsigned wc;
        longint          cyc;
    } exp_t;

    exp_t            sbq[$];
    int              n_checks = 0;
    int              n_fail = 0;
    longint          cycle = 0;
    longint unsigned rate = 0;
    bit              thr_m = 1'b0;
    longint unsigned wc_m = 0;

    task automatic check(input string name, input longint unsigned act,
                         input longint unsigned expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cycle);
        end
    endtask

    // Average mW = (pJ per cycle * 1000) / (ps per cycle), from the window's total energy.
    function automatic longint unsigned predict(input longint unsigned r, input int unsigned f);
        longint unsigned delta, epc, prod, cyc_ps, q;
        if (f == 0) return 0;
        delta  = r * WIN;
        epc    = delta / WIN;
        prod   = (epc > 64'd281474976710) ? 64'd281474976710655 : epc * 1000;
        if (prod > 64'd281474976710655) prod = 64'd281474976710655;
        cyc_ps = 1000000 / f;
        q      = prod / cyc_ps;
        return (q > 65535) ? 65535 : q;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            total = total + rate;
            @(posedge clk);
            #1;
            cycle++;
        end
    endtask

    task automatic start_phase();
        enable = 1'b1;
        tick(1);
    endtask

    task automatic end_phase();
        enable = 1'b0;
        tick(LAT + 10);
    endtask

    // One full window at a constant rate/freq; ready switches to rdy1 at offset sw.
    task automatic window(input longint unsigned r, input int unsigned f, input bit rdy0,
                          input int sw, input bit rdy1);
        exp_t            e;
        longint unsigned p;
        longint unsigned lo;
        rate  = r;
        freq  = 16'(f);
        ready = rdy0;
        p     = predict(r, f);
        lo    = (budget > hyst) ? longint'(budget - hyst) : 0;
        if (budget == 0) thr_m = 1'b0;
        else if (p >= budget) thr_m = 1'b1;
        else if (p < lo) thr_m = 1'b0;
        wc_m++;
        e.power = p;
        e.thr   = thr_m;
        e.wc    = wc_m;
        e.cyc   = cycle + WIN + LAT;
        sbq.push_back(e);
        for (int i = 0; i < int'(WIN); i++) begin
            if (i == sw) ready = rdy1;
            tick(1);
        end
    endtask

    logic [31:0] last_wc = '0;
    bit          prev_acc = 1'b0;
    bit          prev_hold = 1'b0;
    logic [15:0] prev_avg = '0;

    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            last_wc   = '0;
            prev_acc  = 1'b0;
            prev_hold = 1'b0;
        end else begin
            if (window_count != last_wc) begin
                if (sbq.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_sample: window_count %0d with nothing expected",
                             window_count);
                end else begin
                    e = sbq.pop_front();
                    check("avg_power", avg_power_mw, e.power);
                    check("throttle", throttle_req, e.thr);
                    check("window_count", window_count, e.wc);
                    check("post_cycle", cycle, e.cyc);
                    check("valid_on_post", sample_valid, 1);
                end
            end else begin
                if (prev_acc) check("valid_cleared", sample_valid, 0);
                if (prev_hold) begin
                    check("valid_held", sample_valid, 1);
                    check("avg_held", avg_power_mw, prev_avg);
                end
            end
            prev_acc  = sample_valid && ready;
            prev_hold = sample_valid && !ready;
            prev_avg  = avg_power_mw;
            last_wc   = window_count;
        end
    end

    initial begin
        #1 reset = 1'b1;
        #1;
        check("reset_valid", sample_valid, 0);
        check("reset_avg", avg_power_mw, 0);
        check("reset_throttle", throttle_req, 0);
        check("reset_overrun", sample_overrun, 0);
        check("reset_wc", window_count, 0);
        tick(3);
        reset = 1'b0;
        tick(2);

        // Basic power and latency, then 200 MHz and a zero-frequency window.
        start_phase(); window(500, 1000, 1, -1, 1); end_phase();
        start_phase(); window(1500, 200, 1, -1, 1); window(1500, 0, 1, -1, 1); end_phase();

        // Counter wrap inside the window.
        rate  = 0;
        total = 64'hFFFF_FFFF_FFFF_FC18;
        start_phase(); window(500, 1000, 1, -1, 1); end_phase();

        // Hysteresis: 500 -> on, 380 inside band -> hold, 340 -> off; budget 0 -> off.
        budget = 16'd400; hyst = 16'd50;
        start_phase();
        window(500, 1000, 1, -1, 1); window(380, 1000, 1, -1, 1); window(340, 1000, 1, -1, 1);
        end_phase();
        budget = 16'd0;
        start_phase(); window(500, 1000, 1, -1, 1); end_phase();

        // Handshake: coinciding post/accept, then two unconsumed posts.
        start_phase();
        window(200, 1000, 1, -1, 1);
        window(300, 1000, 1, 48, 0);
        window(400, 1000, 0, 48, 1);
        check("no_overrun_on_coincide", sample_overrun, 0);
        window(500, 1000, 1, 48, 0);
        window(600, 1000, 0, -1, 0);
        check("overrun_set", sample_overrun, 1);
        check("overrun_avg_second", avg_power_mw, 500);
        check("overrun_valid", sample_valid, 1);
        end_phase();
        ready = 1'b1;
        tick(2);

        // Enable dropped mid-RUN: partial window discarded.
        start_phase(); window(700, 1000, 1, -1, 1);
        tick(55); enable = 1'b0; tick(100);
        check("no_post_after_run_drop", window_count, wc_m);

        // Enable dropped mid-DIV: sample still posts, then idle.
        budget = 16'd400;
        start_phase(); window(800, 1000, 1, -1, 1);
        tick(10); enable = 1'b0; tick(LAT + 80);
        check("idle_after_div_drop", window_count, wc_m);
        check("throttle_before_reset", throttle_req, 1);

        // Reset during the divide.
        start_phase(); window(900, 1000, 1, -1, 1);
        tick(20);
        reset = 1'b1; enable = 1'b0;
        #1;
        check("midreset_valid", sample_valid, 0);
        check("midreset_avg", avg_power_mw, 0);
        check("midreset_throttle", throttle_req, 0);
        check("midreset_overrun", sample_overrun, 0);
        check("midreset_wc", window_count, 0);
        sbq.delete();
        wc_m  = 0;
        thr_m = 1'b0;
        tick(3);
        reset = 1'b0;
        tick(2);
        start_phase(); window(450, 1000, 1, -1, 1); end_phase();

        // Randomized windows, including zero frequency and a saturating rate.
        budget = 16'($urandom_range(100, 3000));
        hyst   = 16'($urandom_range(0, 300));
        start_phase();
        for (int i = 0; i < 10; i++) begin
            longint unsigned r;
            int unsigned     f;
            r = (i == 7) ? (64'd1 << 40) : longint'($urandom_range(0, 4000));
            f = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 2000);
            window(r, f, 1, -1, 1);
        end
        end_phase();

        check("scoreboard_drained", sbq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
